// File: rtl/br_rd_unpack64.sv
// -----------------------------------------------------------------------------
// br_rd_unpack64
//
// Read-side unloader for the 4x32 asynchronous bridge FIFO. Runs entirely in
// the FIFO read-clock domain. Pops 32-bit words and pairs them into 64-bit
// beats: the first word goes to [31:0] and the second to [63:32]. Beats are
// presented on a valid/ready stream toward the 64-bit LMAC datapath.
//
// A lone trailing word is emitted as a half beat (keep=2'b01, upper word
// zero) in two cases: after TMO idle cycles, or when flush is asserted.
//
// Parameters:
//   TMO  idle cycles a lone low word waits before auto-flush (1..255)
//   TW   timeout counter width, 2^TW > TMO
//
// Ports:
//   clk           read-side clock (same as FIFO rdclk)
//   aclr          asynchronous active-high reset
//   fifo_rdreq    FIFO read request (combinational)
//   fifo_q        FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdempty  FIFO empty flag
//   flush         force emission of a held lone word
//   out_data      packed 64-bit beat
//   out_keep      word enables (2'b11 full beat, 2'b01 low word only)
//   out_valid     beat valid
//   out_ready     downstream accept
//   wcnt          (only with BR_RD_UNPACK_CNT_EN) saturating count of
//                 32-bit words accepted downstream
//
// Optional feature macro: BR_RD_UNPACK_CNT_EN
// -----------------------------------------------------------------------------
module br_rd_unpack64 #(
   parameter int TMO = 8,
   parameter int TW  = 8
) (
   input  logic        clk,
   input  logic        aclr,
   output logic        fifo_rdreq,
   input  logic [31:0] fifo_q,
   input  logic        fifo_rdempty,
   input  logic        flush,
   output logic [63:0] out_data,
   output logic [1:0]  out_keep,
   output logic        out_valid,
   input  logic        out_ready
`ifdef BR_RD_UNPACK_CNT_EN
   ,
   output logic [15:0] wcnt
`endif
);

   localparam logic [TW-1:0] TMO_C = TW'(TMO);

   // Held low word and its valid flag
   logic [31:0]   lo_q, lo_d;
   logic          lo_vld_q, lo_vld_d;
   // A read was issued last cycle, so fifo_q carries a word this cycle
   logic          pend_q;
   // Output register
   logic [63:0]   out_data_q, out_data_d;
   logic [1:0]    out_keep_q, out_keep_d;
   logic          out_valid_q, out_valid_d;
   // Idle timeout counter
   logic [TW-1:0] cnt_q, cnt_d;

   logic [1:0]    occ;
   logic          out_free;
   logic          flush_fire;
   logic          rdreq;

   // Words currently owned by the pairing stage (held + in flight)
   assign occ      = {1'b0, lo_vld_q} + {1'b0, pend_q};
   assign out_free = !out_valid_q || out_ready;

   assign flush_fire = lo_vld_q && !pend_q && out_free &&
                       (flush || (cnt_q == TMO_C));

   // A second word is only requested when the output register will be free
   // by the time it pairs, so a completed pair never has to wait.
   assign rdreq = !aclr && !fifo_rdempty && !flush_fire &&
                  ((occ == 2'd0) || ((occ == 2'd1) && out_free));

   assign fifo_rdreq = rdreq;
   assign out_data   = out_data_q;
   assign out_keep   = out_keep_q;
   assign out_valid  = out_valid_q;

   always_comb begin
      lo_d        = lo_q;
      lo_vld_d    = lo_vld_q;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_valid_d = out_valid_q;
      cnt_d       = '0;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (pend_q) begin
         if (!lo_vld_q) begin
            lo_d     = fifo_q;
            lo_vld_d = 1'b1;
         end else begin
            out_data_d  = {fifo_q, lo_q};
            out_keep_d  = 2'b11;
            out_valid_d = 1'b1;
            lo_vld_d    = 1'b0;
         end
      end else if (flush_fire) begin
         out_data_d  = {32'h0, lo_q};
         out_keep_d  = 2'b01;
         out_valid_d = 1'b1;
         lo_vld_d    = 1'b0;
      end

      // Count only truly idle cycles of a held word; saturate at TMO
      if (!flush_fire && lo_vld_q && !pend_q && fifo_rdempty) begin
         cnt_d = (cnt_q == TMO_C) ? cnt_q : cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         lo_q        <= '0;
         lo_vld_q    <= 1'b0;
         pend_q      <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         lo_q        <= lo_d;
         lo_vld_q    <= lo_vld_d;
         pend_q      <= rdreq;
         out_data_q  <= out_data_d;
         out_keep_q  <= out_keep_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef BR_RD_UNPACK_CNT_EN
   logic [15:0] wcnt_q, wcnt_d;
   logic [16:0] wcnt_sum;

   always_comb begin
      wcnt_sum = {1'b0, wcnt_q};
      if (out_valid_q && out_ready) begin
         wcnt_sum = {1'b0, wcnt_q} + ((out_keep_q == 2'b11) ? 17'd2 : 17'd1);
      end
      wcnt_d = wcnt_sum[16] ? 16'hFFFF : wcnt_sum[15:0];
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         wcnt_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
      end
   end

   assign wcnt = wcnt_q;
`endif

endmodule

// File: tb/tb_br_rd_unpack64.sv
// -----------------------------------------------------------------------------
// tb_br_rd_unpack64
//
// Directed bench for br_rd_unpack64. A small FIFO model feeds the DUT; the
// expected stream is a queue of beats written down per test from the word
// order, and a monitor compares every accepted beat against it, checks that
// a stalled beat stays stable, and (with BR_RD_UNPACK_CNT_EN) tracks the
// accepted word count. Timing points are pinned with literal expectations.
// -----------------------------------------------------------------------------
module tb_br_rd_unpack64;

   logic        clk = 1'b0;
   logic        aclr;
   logic        fifo_rdreq;
   logic [31:0] fifo_q;
   logic        fifo_rdempty;
   logic        flush;
   logic [63:0] out_data;
   logic [1:0]  out_keep;
   logic        out_valid;
   logic        out_ready;
`ifdef BR_RD_UNPACK_CNT_EN
   logic [15:0] wcnt;
`endif

   always #5 clk = ~clk;

   br_rd_unpack64 #(.TMO(8), .TW(8)) dut (
      .clk          (clk),
      .aclr         (aclr),
      .fifo_rdreq   (fifo_rdreq),
      .fifo_q       (fifo_q),
      .fifo_rdempty (fifo_rdempty),
      .flush        (flush),
      .out_data     (out_data),
      .out_keep     (out_keep),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
`ifdef BR_RD_UNPACK_CNT_EN
      ,
      .wcnt         (wcnt)
`endif
   );

   // ---------------- FIFO model ----------------
   logic [31:0] fmem [0:255];
   int          wr_n = 0;
   int          rd_n = 0;

   assign fifo_rdempty = (wr_n == rd_n);

   always @(posedge clk) begin
      if (fifo_rdreq) begin
         fifo_q <= fmem[rd_n[7:0]];
         rd_n   <= rd_n + 1;
      end else begin
         fifo_q <= 32'hA5A5A5A5;   // junk when no read, to expose stray captures
      end
   end

   task automatic push(input logic [31:0] w);
      fmem[wr_n[7:0]] = w;
      wr_n = wr_n + 1;
   endtask

   // ---------------- checking ----------------
   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   logic [65:0] sb[$];

   task automatic expect_beat(input logic [63:0] d, input logic [1:0] k);
      sb.push_back({k, d});
   endtask

   // Monitor: samples 1 time unit before each rising edge
   logic        held_prev = 1'b0;
   logic [63:0] prev_data;
   logic [1:0]  prev_keep;
   int          n_beats = 0;
`ifdef BR_RD_UNPACK_CNT_EN
   int          wmod = 0;
`endif

   initial begin
      logic [65:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (aclr) begin
            held_prev = 1'b0;
`ifdef BR_RD_UNPACK_CNT_EN
            wmod = 0;
            chk("wcnt_reset", {48'h0, wcnt}, 64'h0);
`endif
         end else begin
            if (held_prev) begin
               chk("hold_data", out_data, prev_data);
               chk("hold_keep", {62'h0, out_keep}, {62'h0, prev_keep});
            end
`ifdef BR_RD_UNPACK_CNT_EN
            chk("wcnt", {48'h0, wcnt}, 64'(wmod));
`endif
            if (out_valid && out_ready) begin
               n_beats = n_beats + 1;
               $display("beat %0d data=%h keep=%b", n_beats, out_data, out_keep);
               if (sb.size() == 0) begin
                  n_chk  = n_chk + 1;
                  n_fail = n_fail + 1;
                  $display("FAIL unexpected_beat: got %h keep %b expected none", out_data, out_keep);
               end else begin
                  e = sb.pop_front();
                  chk("beat_data", out_data, e[63:0]);
                  chk("beat_keep", {62'h0, out_keep}, {62'h0, e[65:64]});
               end
`ifdef BR_RD_UNPACK_CNT_EN
               wmod = wmod + ((out_keep == 2'b11) ? 2 : 1);
               if (wmod > 65535) wmod = 65535;
`endif
            end
            held_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_keep = out_keep;
         end
      end
   end

   // Wait until all expected beats are seen and the FIFO is drained
   task automatic drain(input string nm);
      int i;
      for (i = 0; i < 60; i++) begin
         if (sb.size() == 0 && wr_n == rd_n && !out_valid) break;
         @(negedge clk);
         #1;
      end
      chk(nm, 64'(i < 60), 64'h1);
      repeat (3) @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      aclr      = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;

      // Reset with a non-empty FIFO; the word then times out as a half beat
      push(32'hDEADBEEF);
      expect_beat({32'h0, 32'hDEADBEEF}, 2'b01);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdreq", {63'h0, fifo_rdreq}, 64'h0);
      chk("rst_valid", {63'h0, out_valid}, 64'h0);
      chk("rst_data", out_data, 64'h0);
      chk("rst_keep", {62'h0, out_keep}, 64'h0);
      @(negedge clk);
      aclr = 1'b0;
      #1;
      chk("first_rdreq", {63'h0, fifo_rdreq}, 64'h1);
      for (k = 1; k < 40; k++) begin
         @(negedge clk);
         #1;
         if (out_valid) break;
      end
      // read, capture, 8 idle cycles, fire, then visible
      chk("timeout_latency", 64'(k), 64'd11);
      chk("timeout_keep", {62'h0, out_keep}, 64'h1);
      drain("drain_timeout");

      // Pairing and sustained throughput: 6 words, beats every 3 cycles
      @(negedge clk);
      push(32'h11111111); push(32'h22222222); push(32'h33333333);
      push(32'h44444444); push(32'h55555555); push(32'h66666666);
      expect_beat(64'h22222222_11111111, 2'b11);
      expect_beat(64'h44444444_33333333, 2'b11);
      expect_beat(64'h66666666_55555555, 2'b11);
      #1;
      chk("pair_rdreq", {63'h0, fifo_rdreq}, 64'h1);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         #1;
         chk("tput_valid", {63'h0, out_valid}, 64'(c == 3 || c == 6 || c == 9));
         if (c == 3) begin
            chk("pair_data", out_data, 64'h22222222_11111111);
            chk("pair_keep", {62'h0, out_keep}, 64'h3);
         end
      end
      drain("drain_pair");

      // Backpressure: 8 words, out_ready low for 20 cycles
      @(negedge clk);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(32'hB0000000 + 32'(i));
      for (int i = 0; i < 8; i += 2)
         expect_beat({32'hB0000000 + 32'(i + 1), 32'hB0000000 + 32'(i)}, 2'b11);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         #1;
         if (c >= 4) chk("bp_no_rdreq", {63'h0, fifo_rdreq}, 64'h0);
      end
      chk("bp_reads", 64'(rd_n - (wr_n - 8)), 64'd3);
      chk("bp_valid", {63'h0, out_valid}, 64'h1);
      chk("bp_data", out_data, 64'hB0000001_B0000000);
      @(negedge clk);
      out_ready = 1'b1;
      drain("drain_bp");

      // Flush in the same cycle a new word arrives
      @(negedge clk);
      push(32'hF1F1F1F1);
      expect_beat({32'h0, 32'hF1F1F1F1}, 2'b01);
      expect_beat(64'h0C0C0C0C_0B0B0B0B, 2'b11);
      #1;
      for (int i = 0; i < 10; i++) begin
         if (rd_n == wr_n) break;
         @(negedge clk);
         #1;
      end
      @(negedge clk);
      flush = 1'b1;
      push(32'h0B0B0B0B);
      #1;
      chk("flush_rdreq", {63'h0, fifo_rdreq}, 64'h0);
      @(negedge clk);
      push(32'h0C0C0C0C);
      #1;
      chk("flush_valid", {63'h0, out_valid}, 64'h1);
      chk("flush_data", out_data, 64'h00000000_F1F1F1F1);
      chk("flush_keep", {62'h0, out_keep}, 64'h1);
      // flush held while lo is empty or a read is pending must do nothing
      repeat (3) @(negedge clk);
      flush = 1'b0;
      #1;
      drain("drain_flush");

      // Mid-stream reset with a read in flight and a beat pending
      @(negedge clk);
      out_ready = 1'b0;
      push(32'hC0000000); push(32'hC0000001);
      push(32'hC0000002); push(32'hC0000003);
      for (int c = 1; c <= 4; c++) @(negedge clk);
      chk("mr_pre_valid", {63'h0, out_valid}, 64'h1);
      chk("mr_pre_reads", 64'(wr_n - rd_n), 64'd1);
      aclr = 1'b1;
      #1;
      chk("mr_valid", {63'h0, out_valid}, 64'h0);
      chk("mr_data", out_data, 64'h0);
      chk("mr_keep", {62'h0, out_keep}, 64'h0);
      chk("mr_rdreq", {63'h0, fifo_rdreq}, 64'h0);
      @(negedge clk);
      aclr      = 1'b0;
      out_ready = 1'b1;
      expect_beat({32'h0, 32'hC0000003}, 2'b01);
      #1;
      drain("drain_mr");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
